// File: rtl/fb_write_arbiter_if.sv
// Frame-buffer write arbiter bus: three requester write ports, the downstream memory write port
// and the arbiter status. The master view belongs to the arbiter, the slave view to its environment.
interface fb_write_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [2:0]          req_valid;
  logic [2:0]          req_ready;
  logic [2:0]          req_last;
  logic [3*ADDR_W-1:0] req_addr;
  logic [3*DATA_W-1:0] req_din;
  logic [11:0]         req_we;
  logic                mem_valid;
  logic                mem_ready;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_din;
  logic [3:0]          mem_we;
  logic [1:0]          grant_id;
  logic                busy;

  modport master (
    input  req_valid, req_last, req_addr, req_din, req_we, mem_ready,
    output req_ready, mem_valid, mem_addr, mem_din, mem_we, grant_id, busy
  );

  modport slave (
    output req_valid, req_last, req_addr, req_din, req_we, mem_ready,
    input  req_ready, mem_valid, mem_addr, mem_din, mem_we, grant_id, busy
  );
endinterface

// File: rtl/fb_write_arbiter.sv
// Shares the frame-buffer write path among CPU bypass (0), filler (1) and line engine (2) with burst grants.
// Optional macro FB_ARB_CPU_PRIORITY_EN: requester 0 always wins arbitration; round-robin only among 1 and 2.
module fb_write_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fb_write_arbiter_if.master   bus_io
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam int               CNT_W    = $clog2(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
  localparam logic [1:0]       GNT_NONE = 2'd3;

  state_t            state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic [1:0]        last_owner_q, last_owner_d;
  logic [1:0]        winner_s;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_valid_q, mem_valid_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d, sel_addr_s;
  logic [DATA_W-1:0] mem_din_q, mem_din_d, sel_din_s;
  logic [3:0]        mem_we_q, mem_we_d, sel_we_s;
  logic              sel_valid_s, sel_last_s;
  logic              ready_s, accept_s, release_s;

`ifdef FB_ARB_CPU_PRIORITY_EN
  function automatic logic [1:0] pick_winner(input logic [2:0] valid, input logic [1:0] last);
    logic [1:0] pick;
    if (valid[0]) begin
      pick = 2'd0;
    end else if (last == 2'd1) begin
      if (valid[2])      pick = 2'd2;
      else if (valid[1]) pick = 2'd1;
      else               pick = GNT_NONE;
    end else begin
      if (valid[1])      pick = 2'd1;
      else if (valid[2]) pick = 2'd2;
      else               pick = GNT_NONE;
    end
    return pick;
  endfunction
`else
  function automatic logic [1:0] pick_winner(input logic [2:0] valid, input logic [1:0] last);
    logic [1:0] pick;
    case (last)
      2'd0: begin
        if (valid[1])      pick = 2'd1;
        else if (valid[2]) pick = 2'd2;
        else if (valid[0]) pick = 2'd0;
        else               pick = GNT_NONE;
      end
      2'd1: begin
        if (valid[2])      pick = 2'd2;
        else if (valid[0]) pick = 2'd0;
        else if (valid[1]) pick = 2'd1;
        else               pick = GNT_NONE;
      end
      default: begin
        if (valid[0])      pick = 2'd0;
        else if (valid[1]) pick = 2'd1;
        else if (valid[2]) pick = 2'd2;
        else               pick = GNT_NONE;
      end
    endcase
    return pick;
  endfunction
`endif

  assign winner_s = pick_winner(bus_io.req_valid, last_owner_q);

  // Route the current owner's beat to the shared datapath
  always_comb begin
    sel_valid_s = 1'b0;
    sel_last_s  = 1'b0;
    sel_addr_s  = '0;
    sel_din_s   = '0;
    sel_we_s    = 4'h0;
    case (grant_q)
      2'd0: begin
        sel_valid_s = bus_io.req_valid[0];
        sel_last_s  = bus_io.req_last[0];
        sel_addr_s  = bus_io.req_addr[0 +: ADDR_W];
        sel_din_s   = bus_io.req_din[0 +: DATA_W];
        sel_we_s    = bus_io.req_we[3:0];
      end
      2'd1: begin
        sel_valid_s = bus_io.req_valid[1];
        sel_last_s  = bus_io.req_last[1];
        sel_addr_s  = bus_io.req_addr[ADDR_W +: ADDR_W];
        sel_din_s   = bus_io.req_din[DATA_W +: DATA_W];
        sel_we_s    = bus_io.req_we[7:4];
      end
      2'd2: begin
        sel_valid_s = bus_io.req_valid[2];
        sel_last_s  = bus_io.req_last[2];
        sel_addr_s  = bus_io.req_addr[2*ADDR_W +: ADDR_W];
        sel_din_s   = bus_io.req_din[2*DATA_W +: DATA_W];
        sel_we_s    = bus_io.req_we[11:8];
      end
      default: begin
        sel_valid_s = 1'b0;
      end
    endcase
  end

  // The output register may take a new beat whenever it is empty or being drained this cycle
  assign ready_s          = (state_q == ST_GRANT) && (!mem_valid_q || bus_io.mem_ready);
  assign accept_s         = ready_s && sel_valid_s;
  assign release_s        = accept_s && (sel_last_s || (cnt_q == CNT_LAST));
  assign bus_io.req_ready = ready_s ? (3'b001 << grant_q) : 3'b000;

  // Grant FSM: next state, owner, beat count and round-robin pointer
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    cnt_d        = cnt_q;
    last_owner_d = last_owner_q;
    case (state_q)
      ST_IDLE: begin
        if (|bus_io.req_valid) begin
          state_d = ST_GRANT;
          grant_d = winner_s;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (release_s) begin
          state_d = ST_IDLE;
          grant_d = GNT_NONE;
          cnt_d   = '0;
`ifdef FB_ARB_CPU_PRIORITY_EN
          if (grant_q != 2'd0) begin
            last_owner_d = grant_q;
          end else begin
            last_owner_d = last_owner_q;
          end
`else
          last_owner_d = grant_q;
`endif
        end else if (accept_s) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = GNT_NONE;
        cnt_d   = '0;
      end
    endcase
  end

  // Downstream output register: load on accept, drain on mem_ready, hold under backpressure
  always_comb begin
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;
    mem_we_d    = mem_we_q;
    if (accept_s) begin
      mem_valid_d = 1'b1;
      mem_addr_d  = sel_addr_s;
      mem_din_d   = sel_din_s;
      mem_we_d    = sel_we_s;
    end else if (bus_io.mem_ready) begin
      mem_valid_d = 1'b0;
    end else begin
      mem_valid_d = mem_valid_q;
    end
    busy_d = (state_d == ST_GRANT) || mem_valid_d;
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= GNT_NONE;
      cnt_q        <= '0;
      last_owner_q <= 2'd2;
      mem_valid_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_din_q    <= '0;
      mem_we_q     <= 4'h0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      cnt_q        <= cnt_d;
      last_owner_q <= last_owner_d;
      mem_valid_q  <= mem_valid_d;
      mem_addr_q   <= mem_addr_d;
      mem_din_q    <= mem_din_d;
      mem_we_q     <= mem_we_d;
      busy_q       <= busy_d;
    end
  end

  assign bus_io.mem_valid = mem_valid_q;
  assign bus_io.mem_addr  = mem_addr_q;
  assign bus_io.mem_din   = mem_din_q;
  assign bus_io.mem_we    = mem_we_q;
  assign bus_io.grant_id  = grant_q;
  assign bus_io.busy      = busy_q;

endmodule
